ram_frame_loader: RTL and testbench

//  Upstream feeder for the register-bank RAM. Collects SIZE-bit words one per

---
 rtl/ram_frame_loader_pkg.sv | 14 +
 rtl/ram_frame_loader_word_counter.sv | 26 ++
 rtl/ram_frame_loader.sv | 106 ++++++++++
 tb/tb_ram_frame_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_frame_loader_pkg.sv
// Shared definitions for the RAM frame loader: FSM encoding and counter widths.
package ram_frame_loader_pkg;

  localparam int FRAME_CNT_W = 16;

  localparam logic ST_FILL_ENC = 1'b0;
  localparam logic ST_LOAD_ENC = 1'b1;

  typedef enum logic {
    ST_FILL = ST_FILL_ENC,
    ST_LOAD = ST_LOAD_ENC
  } state_t;

endpackage

// File: rtl/ram_frame_loader_word_counter.sv
// Mod-WIDTH up counter tracking the next free slot of the frame buffer.
module word_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ram_frame_loader.sv
// Collects SIZE-bit words into a WIDTH-slot frame and strobes ld for one cycle
// when the frame is full or a flush pads a partial frame.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_FILL | accepting words (in_ready=1), frame buffer filling
// ST_LOAD | frame complete, ld=1 for exactly one cycle, par_out stable
module ram_frame_loader
  import ram_frame_loader_pkg::*;
#(
  parameter  int SIZE  = 16,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [SIZE-1:0]        in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   ld,
  output logic [WIDTH*SIZE-1:0]  par_out,
  output logic [CW-1:0]          count,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  state_t state, state_d;

  logic [WIDTH-1:0][SIZE-1:0] buf_q, buf_d;
  logic xfer;
  logic tc;
  logic flush_go;
  logic cnt_clr;

  // in_ready is gated by rst so the source sees no ready while held in reset
  assign in_ready = rst && (state == ST_FILL);
  assign ld       = (state == ST_LOAD);
  assign xfer     = in_valid && in_ready;
  assign par_out  = buf_q;

  // a flush only acts when the frame will hold at least one word
  assign flush_go = flush && (state == ST_FILL) && ((count != '0) || xfer);
  assign cnt_clr  = clr || flush_go;

  word_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_word_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (xfer),
    .count (count),
    .tc    (tc)
  );

  always_comb begin
    int zstart;
    buf_d  = buf_q;
    zstart = int'(count) + (xfer ? 1 : 0);
    if (clr) begin
      buf_d = '0;
    end else begin
      if (xfer) begin
        buf_d[count] = in_data;
      end
      if (flush_go) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= zstart) begin
            buf_d[i] = '0;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    if (clr) begin
      state_d = ST_FILL;
    end else begin
      case (state)
        ST_FILL: if ((xfer && tc) || flush_go) state_d = ST_LOAD;
        ST_LOAD: state_d = ST_FILL;
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FILL;
      buf_q     <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_d;
      buf_q <= buf_d;
      // counted at the close of the strobe, even if clr arrives in that cycle
      if (state == ST_LOAD) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_frame_loader.sv
// Directed self-checking bench for ram_frame_loader (SIZE=16, WIDTH=8).
module tb_ram_frame_loader;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_ready;
  logic         flush;
  logic         ld;
  logic [127:0] par_out;
  logic [2:0]   count;
  logic [15:0]  frame_cnt;

  int errors = 0;
  int checks = 0;
  int ld_pulses = 0;

  ram_frame_loader #(.SIZE(16), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .ld        (ld),
    .par_out   (par_out),
    .count     (count),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ld === 1'b1) ld_pulses++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] exp;
    int p0;
    int idx;
    int f;
    int cyc;
    bit acc;

    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;

    // reset state
    #2;
    chk("rst_ld", ld, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_par_out", par_out, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    #10 rst = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();

    // full frame 0x1111..0x8888
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("full_ld_before_last", ld, 0);
      send_word(16'((i + 1) * 16'h1111));
    end
    exp = '0;
    for (int i = 0; i < 8; i++) exp[i*16 +: 16] = 16'((i + 1) * 16'h1111);
    chk("full_ld", ld, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 0);
    chk("full_par_out", par_out, exp);
    chk("full_frame_cnt_during_ld", frame_cnt, 0);
    tick();
    chk("full_ld_after", ld, 0);
    chk("full_in_ready_after", in_ready, 1);
    chk("full_frame_cnt", frame_cnt, 1);

    // partial frame + flush
    send_word(16'hA001);
    send_word(16'hA002);
    send_word(16'hA003);
    chk("partial_count", count, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ld", ld, 1);
    chk("flush_count", count, 0);
    chk("flush_par_out", par_out, {80'h0, 16'hA003, 16'hA002, 16'hA001});
    tick();
    chk("flush_ld_after", ld, 0);
    chk("flush_frame_cnt", frame_cnt, 2);

    // flush with empty frame, and flush during LOAD
    p0 = ld_pulses;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("empty_flush_ld", ld, 0);
    chk("empty_flush_frame_cnt", frame_cnt, 2);
    for (int i = 0; i < 8; i++) send_word(16'(16'hC000 + i));
    chk("c_frame_ld", ld, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("load_flush_ld", ld, 0);
    chk("load_flush_count", count, 0);
    tick();
    chk("load_flush_ld2", ld, 0);
    chk("load_flush_pulses", ld_pulses - p0, 1);
    chk("load_flush_frame_cnt", frame_cnt, 3);

    // partial frame aborted by clr, then B-frame
    for (int i = 0; i < 5; i++) send_word(16'(16'hD000 + i));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_par_out", par_out, 0);
    chk("clr_ld", ld, 0);
    chk("clr_frame_cnt", frame_cnt, 3);
    p0 = ld_pulses;
    for (int i = 0; i < 8; i++) send_word(16'(16'hB000 + i));
    exp = '0;
    for (int i = 0; i < 8; i++) exp[i*16 +: 16] = 16'(16'hB000 + i);
    chk("b_ld", ld, 1);
    chk("b_par_out", par_out, exp);
    // clr during LOAD keeps the strobe for this cycle
    clr = 1'b1;
    #1;
    chk("clr_in_load_ld", ld, 1);
    tick();
    clr = 1'b0;
    chk("clr_in_load_ld_after", ld, 0);
    chk("clr_in_load_par_out", par_out, 0);
    chk("clr_in_load_frame_cnt", frame_cnt, 4);
    chk("b_pulses", ld_pulses - p0, 1);

    // random valid over 80 words
    p0 = ld_pulses;
    idx = 0; f = 0; cyc = 0;
    while ((idx < 80 || ld === 1'b1) && cyc < 2000) begin
      if (idx < 80) begin
        if (!in_valid) in_valid = 1'($urandom_range(0, 1));
        in_data = 16'(16'h5000 + idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (ld === 1'b1) begin
        exp = '0;
        for (int j = 0; j < 8; j++) exp[j*16 +: 16] = 16'(16'h5000 + f*8 + j);
        chk($sformatf("rand_frame%0d", f), par_out, exp);
        f++;
      end
      tick();
      if (acc) begin
        idx++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_timeout", cyc < 2000, 1);
    chk("rand_words", idx, 80);
    chk("rand_frames", f, 10);
    chk("rand_pulses", ld_pulses - p0, 10);
    chk("rand_frame_cnt", frame_cnt, 14);

    // async reset mid-frame
    for (int i = 0; i < 3; i++) send_word(16'(16'hE000 + i));
    #3 rst = 1'b0;
    #1;
    chk("arst_mid_count", count, 0);
    chk("arst_mid_par_out", par_out, 0);
    chk("arst_mid_ld", ld, 0);
    chk("arst_mid_in_ready", in_ready, 0);
    chk("arst_mid_frame_cnt", frame_cnt, 0);
    #2 rst = 1'b1;
    tick();

    // async reset during LOAD
    for (int i = 0; i < 8; i++) send_word(16'(16'hF000 + i));
    chk("arst_load_ld_before", ld, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_load_ld", ld, 0);
    chk("arst_load_par_out", par_out, 0);
    chk("arst_load_count", count, 0);
    #2 rst = 1'b1;
    tick();
    chk("arst_load_in_ready", in_ready, 1);
    chk("arst_load_frame_cnt", frame_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
